// File: rtl/dispatch_pkg.sv
// Shared widths and slot index type for the in-order dispatcher and its collector.
package dispatch_pkg;
   localparam int N_OUTPUTS = 4;
   localparam int WIDTH     = 16;
   localparam int IDX_W     = $clog2(N_OUTPUTS);
   localparam int CNT_W     = $clog2(N_OUTPUTS + 1);

   typedef logic [IDX_W-1:0] slot_idx_t;
endpackage

// File: rtl/rr_wrap_counter.sv
// Round-robin slot index: advances by one when enabled, wraps from N-1 to 0.
// Registered output, no backpressure of its own; the enable is the only control.
module rr_wrap_counter #(
   parameter int N = 4,
   parameter int W = $clog2(N)
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         en_i,
   output logic [W-1:0] cnt_o
);
   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (en_i) begin
         cnt_d = (cnt_q == W'(N - 1)) ? '0 : cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign cnt_o = cnt_q;
endmodule

// File: rtl/dispatch_in_order.sv
// Strict round-robin dispatcher: start pulse one cycle after accept.
// Stalls (up_rdy_o=0) while the slot under the pointer is still busy; never skips ahead.
module dispatch_in_order
   import dispatch_pkg::*;
#(
   parameter int width     = WIDTH,
   parameter int n_outputs = N_OUTPUTS
) (
   input  logic                                 clk_i,
   input  logic                                 rst_i,
   input  logic                                 up_vld_i,
   output logic                                 up_rdy_o,
   input  logic [width-1:0]                     up_data_i,
   output logic [n_outputs-1:0]                 down_vlds_o,
   output logic [n_outputs-1:0][width-1:0]      down_data_o,
   input  logic [n_outputs-1:0]                 slot_done_i,
   output logic [$clog2(n_outputs+1)-1:0]       in_flight_o,
   output logic                                 err_o
);
   localparam int PW = $clog2(n_outputs);
   localparam int CW = $clog2(n_outputs + 1);

   logic [PW-1:0]                     ptr;
   logic                              accept;
   logic [n_outputs-1:0]              done_ok;
   logic [CW-1:0]                     done_cnt;

   logic [n_outputs-1:0]              busy_q,      busy_d;
   logic [n_outputs-1:0]              down_vlds_q, down_vlds_d;
   logic [n_outputs-1:0][width-1:0]   down_data_q, down_data_d;
   logic [CW-1:0]                     in_flight_q, in_flight_d;
   logic                              err_q,       err_d;

   rr_wrap_counter #(.N(n_outputs), .W(PW)) u_ptr (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .en_i  (accept),
      .cnt_o (ptr)
   );

   // A done on the head slot frees it in time for this cycle's accept (bypass).
   assign up_rdy_o = !busy_q[ptr] | slot_done_i[ptr];
   assign accept   = up_vld_i & up_rdy_o;
   assign done_ok  = slot_done_i & busy_q;

   always_comb begin
      done_cnt = '0;
      for (int i = 0; i < n_outputs; i++) begin
         done_cnt = done_cnt + CW'(done_ok[i]);
      end
   end

   always_comb begin
      busy_d      = busy_q & ~slot_done_i;
      down_vlds_d = '0;
      down_data_d = down_data_q;
      in_flight_d = in_flight_q + CW'(accept) - done_cnt;
      err_d       = err_q | (|(slot_done_i & ~busy_q));
      if (accept) begin
         busy_d[ptr]      = 1'b1;
         down_vlds_d[ptr] = 1'b1;
         down_data_d[ptr] = up_data_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         busy_q      <= '0;
         down_vlds_q <= '0;
         down_data_q <= '0;
         in_flight_q <= '0;
         err_q       <= 1'b0;
      end else begin
         busy_q      <= busy_d;
         down_vlds_q <= down_vlds_d;
         down_data_q <= down_data_d;
         in_flight_q <= in_flight_d;
         err_q       <= err_d;
      end
   end

   assign down_vlds_o = down_vlds_q;
   assign down_data_o = down_data_q;
   assign in_flight_o = in_flight_q;
   assign err_o       = err_q;
endmodule

// File: tb/tb_dispatch_in_order.sv
// Scoreboard bench for dispatch_in_order: reference model of ptr/busy/err plus a job queue.
module tb_dispatch_in_order;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int CW = $clog2(N + 1);

   logic                  clk = 1'b0;
   logic                  rst = 1'b0;
   logic                  up_vld = 1'b0;
   logic                  up_rdy;
   logic [W-1:0]          up_data = '0;
   logic [N-1:0]          down_vlds;
   logic [N-1:0][W-1:0]   down_data;
   logic [N-1:0]          slot_done = '0;
   logic [CW-1:0]         in_flight;
   logic                  err;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0]          m_busy;
   logic [1:0]            m_ptr;
   logic                  m_err;
   logic [N-1:0][W-1:0]   m_data;
   logic [1+W:0]          sb[$];

   always #5 clk = ~clk;

   dispatch_in_order #(.width(W), .n_outputs(N)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .up_vld_i    (up_vld),
      .up_rdy_o    (up_rdy),
      .up_data_i   (up_data),
      .down_vlds_o (down_vlds),
      .down_data_o (down_data),
      .slot_done_i (slot_done),
      .in_flight_o (in_flight),
      .err_o       (err)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int popcnt(input logic [N-1:0] v);
      int c = 0;
      for (int i = 0; i < N; i++) c += int'(v[i]);
      return c;
   endfunction

   task automatic model_clear();
      m_busy = '0;
      m_ptr  = '0;
      m_err  = 1'b0;
      m_data = '0;
      sb.delete();
   endtask

   task automatic check_outputs_after_edge(input logic [N-1:0] exp_vlds);
      logic [1+W:0] ent;
      int           idx;
      check_eq("down_vlds", 32'(down_vlds), 32'(exp_vlds));
      if (down_vlds != '0) begin
         idx = 0;
         for (int i = 0; i < N; i++) if (down_vlds[i]) idx = i;
         if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
         end else begin
            ent = sb.pop_front();
            check_eq("order_slot", 32'(idx), 32'(ent[W+1:W]));
            check_eq("order_data", 32'(down_data[idx]), 32'(ent[W-1:0]));
         end
      end
      for (int i = 0; i < N; i++) check_eq("down_data_hold", 32'(down_data[i]), 32'(m_data[i]));
      check_eq("in_flight", 32'(in_flight), 32'(popcnt(m_busy)));
      check_eq("err", 32'(err), 32'(m_err));
   endtask

   // One clock of stimulus: drive at negedge, check up_rdy, advance model, check after posedge.
   task automatic step(input logic vld, input logic [W-1:0] dat, input logic [N-1:0] done);
      logic         exp_rdy;
      logic         acc;
      logic [N-1:0] exp_vlds;
      @(negedge clk);
      up_vld    = vld;
      up_data   = dat;
      slot_done = done;
      #1;
      exp_rdy = !m_busy[m_ptr] | done[m_ptr];
      check_eq("up_rdy", 32'(up_rdy), 32'(exp_rdy));
      acc      = vld & exp_rdy;
      m_err    = m_err | (|(done & ~m_busy));
      m_busy   = m_busy & ~done;
      exp_vlds = '0;
      if (acc) begin
         m_busy[m_ptr]   = 1'b1;
         exp_vlds[m_ptr] = 1'b1;
         m_data[m_ptr]   = dat;
         sb.push_back({m_ptr, dat});
         m_ptr = (m_ptr == 2'(N - 1)) ? 2'd0 : m_ptr + 2'd1;
      end
      @(posedge clk);
      #1;
      check_outputs_after_edge(exp_vlds);
      up_vld    = 1'b0;
      slot_done = '0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      up_vld    = 1'b0;
      slot_done = '0;
      rst       = 1'b1;
      model_clear();
      #1;
      check_eq("rst_vlds", 32'(down_vlds), 32'd0);
      check_eq("rst_inflight", 32'(in_flight), 32'd0);
      check_eq("rst_err", 32'(err), 32'd0);
      check_eq("rst_rdy", 32'(up_rdy), 32'd1);
      for (int i = 0; i < N; i++) check_eq("rst_data", 32'(down_data[i]), 32'd0);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic [N-1:0] d;
      model_clear();

      // 1: fill all four slots back to back
      do_reset();
      step(1'b1, 16'h000A, 4'b0000);
      step(1'b1, 16'h000B, 4'b0000);
      step(1'b1, 16'h000C, 4'b0000);
      step(1'b1, 16'h000D, 4'b0000);
      check_eq("t1_inflight4", 32'(in_flight), 32'd4);
      step(1'b1, 16'h00EE, 4'b0000);
      check_eq("t1_stalled_rdy", 32'(up_rdy), 32'd0);

      // 2: freeing slot 2 must not let slot 2 jump ahead of busy slot 0
      step(1'b1, 16'h00EE, 4'b0100);
      check_eq("t2_rdy_after_done2", 32'(up_rdy), 32'd0);
      step(1'b0, 16'h0000, 4'b0001);
      step(1'b1, 16'h000E, 4'b0000);
      check_eq("t2_slot0_data", 32'(down_data[0]), 32'h000E);
      check_eq("t2_inflight", 32'(in_flight), 32'd3);

      // 3: bypass, done and accept on the head slot in the same cycle
      do_reset();
      for (int i = 0; i < N; i++) step(1'b1, 16'(16'h0100 + i), 4'b0000);
      step(1'b1, 16'h0055, 4'b0001);
      check_eq("t3_vlds", 32'(down_vlds), 32'b0001);
      check_eq("t3_inflight", 32'(in_flight), 32'd4);
      step(1'b1, 16'h0066, 4'b0000);

      // 4: done on an idle slot is sticky error only
      do_reset();
      step(1'b0, 16'h0000, 4'b0010);
      check_eq("t4_err", 32'(err), 32'd1);
      step(1'b0, 16'h0000, 4'b0000);
      step(1'b1, 16'h0021, 4'b0000);
      check_eq("t4_err_sticky", 32'(err), 32'd1);

      // 5: asynchronous reset in the middle of a burst
      do_reset();
      step(1'b1, 16'h0031, 4'b0000);
      step(1'b1, 16'h0032, 4'b0000);
      step(1'b1, 16'h0033, 4'b0000);
      #2;
      rst = 1'b1;
      #1;
      check_eq("t5_async_vlds", 32'(down_vlds), 32'd0);
      check_eq("t5_async_inflight", 32'(in_flight), 32'd0);
      check_eq("t5_async_rdy", 32'(up_rdy), 32'd1);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      step(1'b1, 16'h0077, 4'b0000);
      check_eq("t5_first_slot", 32'(down_vlds), 32'b0001);

      // 6: random traffic, only legal dones
      do_reset();
      for (int c = 0; c < 10000; c++) begin
         d = '0;
         for (int i = 0; i < N; i++) d[i] = ($urandom_range(0, 99) < 30);
         step(($urandom_range(0, 99) < 70), 16'($urandom), d & m_busy);
      end
      check_eq("t6_err_clear", 32'(err), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
